reg_write_sched: RTL and testbench



---
 rtl/reg_write_sched_pkg.sv | 32 +++
 rtl/reg_write_sched_if.sv | 39 +++
 rtl/rr_pick6.sv | 34 +++
 rtl/reg_write_sched.sv | 208 ++++++++++++++++++++
 tb/tb_reg_write_sched.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_regsched_pkg
//  Description : Shared constants and types for the FPU register write-port
//                scheduler: mux select codes, source/register counts and
//                the SRAM load state machine encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fpu_regsched_pkg;

    localparam int NUM_SRC  = 6;
    localparam int NUM_REGS = 16;

    // Register mux select codes
    localparam logic [2:0] SEL_D0   = 3'd0;
    localparam logic [2:0] SEL_D1   = 3'd1;
    localparam logic [2:0] SEL_D2   = 3'd2;
    localparam logic [2:0] SEL_D3   = 3'd3;
    localparam logic [2:0] SEL_D4   = 3'd4;
    localparam logic [2:0] SEL_D5   = 3'd5;
    localparam logic [2:0] SEL_HOLD = 3'd6;
    localparam logic [2:0] SEL_SRAM = 3'd7;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_ISSUE = 2'd1,
        LD_WAIT  = 2'd2,
        LD_WRITE = 2'd3
    } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_write_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_sched_if
//  Description : Request/grant and SRAM bus bundle of the register write-port
//                scheduler.
//                master : requesters (src_*/ld_* requests, SRAM side consumer)
//                slave  : scheduler (ready/done, sram_rd/addr, sel_flat,
//                         busy_mask)
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_write_sched_if
    import fpu_regsched_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic [NUM_SRC-1:0]          src_valid;
    logic [NUM_SRC-1:0][3:0]     src_dest;
    logic [NUM_SRC-1:0]          src_ready;
    logic                        ld_valid;
    logic [3:0]                  ld_dest;
    logic [ADDR_W-1:0]           ld_addr;
    logic                        ld_ready;
    logic                        ld_done;
    logic                        sram_rd;
    logic [ADDR_W-1:0]           sram_addr;
    logic [3*NUM_REGS-1:0]       sel_flat;
    logic [NUM_REGS-1:0]         busy_mask;

    modport master (
        output src_valid, src_dest, ld_valid, ld_dest, ld_addr,
        input  src_ready, ld_ready, ld_done, sram_rd, sram_addr, sel_flat, busy_mask
    );

    modport slave (
        input  src_valid, src_dest, ld_valid, ld_dest, ld_addr,
        output src_ready, ld_ready, ld_done, sram_rd, sram_addr, sel_flat, busy_mask
    );
endinterface
`default_nettype wire

// File: rtl/rr_pick6.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick6
//  Description : Combinational rotate-priority picker over six requesters.
//                Scans from ptr upward (mod 6) and returns a one-hot grant.
//  Ports       : req   in  6  request vector
//                ptr   in  3  start index of the scan (0..5)
//                grant out 6  one-hot grant, zero when req is zero
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick6
    import fpu_regsched_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_SRC-1:0] grant
);
    logic [2:0] w_idx;
    logic       w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = 3'((32'(ptr) + k) % NUM_SRC);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/reg_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_sched
//  Description : Write-port scheduler for the 16-entry FPU register bank.
//                Six result sources are arbitrated round-robin per destination
//                register; one SRAM load channel is sequenced by a small FSM
//                and always wins its destination in the cycle before WRITE.
//                sel_flat carries registered 3-bit select codes per register.
//  Ports       : clk, rst (async, active-high)
//                bus (slave modport): src_valid/src_dest/src_ready,
//                ld_valid/ld_dest/ld_addr/ld_ready/ld_done,
//                sram_rd/sram_addr, sel_flat, busy_mask
//  Build macro : REGSCHED_SCOREBOARD_EN - block source writes to a register
//                for the whole ISSUE..WRITE window of a pending load and
//                report that register on busy_mask.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_write_sched
    import fpu_regsched_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int ADDR_W   = 8
)(
    input  logic               clk,
    input  logic               rst,
    reg_write_sched_if.slave   bus
);
    // Last counter value in WAIT before moving to WRITE
    localparam logic [2:0] C_WAIT_LAST = 3'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    ld_state_t             r_state;
    ld_state_t             w_state_nxt;
    logic [3:0]            r_ld_dest;
    logic [ADDR_W-1:0]     r_ld_addr;
    logic [2:0]            r_cnt;
    logic [2:0]            r_rr_ptr;
    logic [2:0]            w_ptr_nxt;
    logic [2:0]            w_idx;
    logic                  w_found;
    logic [3*NUM_REGS-1:0] r_sel;
    logic [3*NUM_REGS-1:0] w_sel_nxt;
    logic [NUM_SRC-1:0]    w_block;
    logic [NUM_SRC-1:0]    w_ready;
    logic [NUM_SRC-1:0]    w_req   [NUM_REGS];
    logic [NUM_SRC-1:0]    w_grant [NUM_REGS];
    logic                  w_resv;
    logic                  w_ld_busy;
    logic [NUM_REGS-1:0]   w_busy_mask;
    logic                  w_ld_ready;
    logic                  w_ld_done;
    logic                  w_sram_rd;
    logic [ADDR_W-1:0]     w_sram_addr;

    // Reservation: the cycle right before WRITE, when the load claims its
    // destination in the select register.
    assign w_resv = ((r_state == LD_WAIT)  && (r_cnt == C_WAIT_LAST)) ||
                    ((r_state == LD_ISSUE) && (LOAD_LAT == 1));

`ifdef REGSCHED_SCOREBOARD_EN
    assign w_ld_busy   = (r_state != LD_IDLE);
    assign w_busy_mask = w_ld_busy ? (16'd1 << r_ld_dest) : '0;
`else
    assign w_ld_busy   = w_resv;
    assign w_busy_mask = '0;
`endif

    always_comb begin
        w_block = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_block[i] = w_ld_busy && (bus.src_dest[i] == r_ld_dest);
        end
    end

    always_comb begin
        for (int d = 0; d < NUM_REGS; d++) begin
            w_req[d] = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                w_req[d][i] = bus.src_valid[i] && !w_block[i] &&
                              (bus.src_dest[i] == 4'(d));
            end
        end
    end

    generate
        for (genvar d = 0; d < NUM_REGS; d++) begin : g_pick
            rr_pick6 u_pick (
                .req   (w_req[d]),
                .ptr   (r_rr_ptr),
                .grant (w_grant[d])
            );
        end
    endgenerate

    always_comb begin
        w_ready = '0;
        for (int d = 0; d < NUM_REGS; d++) begin
            w_ready = w_ready | w_grant[d];
        end
    end

    // Pointer moves past the first accepted source seen in rotated order
    always_comb begin
        w_ptr_nxt = r_rr_ptr;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = 3'((32'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_found && w_ready[w_idx]) begin
                w_found   = 1'b1;
                w_ptr_nxt = (w_idx == 3'd5) ? 3'd0 : (w_idx + 3'd1);
            end
        end
    end

    always_comb begin
        w_sel_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_sel_nxt[3*r +: 3] = SEL_HOLD;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_grant[r][i]) begin
                    w_sel_nxt[3*r +: 3] = SEL_D0 + 3'(i);
                end
            end
            // Sources to this register are already blocked, so no conflict
            if (w_resv && (r_ld_dest == 4'(r))) begin
                w_sel_nxt[3*r +: 3] = SEL_SRAM;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_ready  = 1'b0;
        w_ld_done   = 1'b0;
        w_sram_rd   = 1'b0;
        w_sram_addr = '0;
        case (r_state)
            LD_IDLE: begin
                w_ld_ready = !rst;
                if (bus.ld_valid) begin
                    w_state_nxt = LD_ISSUE;
                end
            end
            LD_ISSUE: begin
                w_sram_rd   = 1'b1;
                w_sram_addr = r_ld_addr;
                w_state_nxt = (LOAD_LAT == 1) ? LD_WRITE : LD_WAIT;
            end
            LD_WAIT: begin
                if (r_cnt == C_WAIT_LAST) begin
                    w_state_nxt = LD_WRITE;
                end
            end
            LD_WRITE: begin
                w_ld_done   = 1'b1;
                w_state_nxt = LD_IDLE;
            end
            default: w_state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_dest <= '0;
            r_ld_addr <= '0;
            r_cnt     <= '0;
        end else begin
            if ((r_state == LD_IDLE) && bus.ld_valid) begin
                r_ld_dest <= bus.ld_dest;
                r_ld_addr <= bus.ld_addr;
            end
            if (r_state == LD_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == LD_WAIT) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= {NUM_REGS{SEL_HOLD}};
            r_rr_ptr <= '0;
        end else begin
            r_sel <= w_sel_nxt;
            if (|w_ready) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus.src_ready = w_ready;
    assign bus.ld_ready  = w_ld_ready;
    assign bus.ld_done   = w_ld_done;
    assign bus.sram_rd   = w_sram_rd;
    assign bus.sram_addr = w_sram_addr;
    assign bus.sel_flat  = r_sel;
    assign bus.busy_mask = w_busy_mask;
endmodule
`default_nettype wire

// File: tb/tb_reg_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_sched
//  Description : Self-checking bench for reg_write_sched (LOAD_LAT=2).
//                Expected select vectors are queued when a request is driven
//                and compared one cycle later against sel_flat.
//                Honours REGSCHED_SCOREBOARD_EN for the busy-window checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_write_sched;
    import fpu_regsched_pkg::*;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    logic [47:0] sb_q [$];
    logic [47:0] exp_sel;
    logic [15:0] exp_busy;

    reg_write_sched_if #(.ADDR_W(8)) bus ();

    reg_write_sched #(.LOAD_LAT(2), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] all_hold();
        logic [47:0] v;
        v = '0;
        for (int r = 0; r < 16; r++) v[3*r +: 3] = 3'd6;
        return v;
    endfunction

    function automatic logic [47:0] sel_with(input logic [47:0] base, input int r, input logic [2:0] c);
        logic [47:0] v;
        v = base;
        v[3*r +: 3] = c;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.src_valid = '0;
        bus.src_dest  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_dest   = '0;
        bus.ld_addr   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.sel_flat !== all_hold()) $display("FAIL reset_sel got=%h want=%h", bus.sel_flat, all_hold()); else pass_cnt++;
        total_cnt++;
        if (bus.src_ready !== 6'b0) $display("FAIL reset_src_ready got=%b want=0", bus.src_ready); else pass_cnt++;
        total_cnt++;
        if (bus.ld_ready !== 1'b0) $display("FAIL reset_ld_ready got=%b want=0", bus.ld_ready); else pass_cnt++;
        total_cnt++;
        if (bus.ld_done !== 1'b0 || bus.sram_rd !== 1'b0) $display("FAIL reset_strobes got=%b%b want=00", bus.ld_done, bus.sram_rd); else pass_cnt++;
        total_cnt++;
        if (bus.sram_addr !== 8'h00 || bus.busy_mask !== 16'h0) $display("FAIL reset_addr_busy got=%h/%h want=00/0000", bus.sram_addr, bus.busy_mask); else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (bus.ld_ready !== 1'b1) $display("FAIL idle_ld_ready got=%b want=1", bus.ld_ready); else pass_cnt++;
        total_cnt++;
        if (bus.sel_flat !== all_hold() || bus.sram_rd !== 1'b0) $display("FAIL idle_sel got=%h rd=%b want=%h rd=0", bus.sel_flat, bus.sram_rd, all_hold()); else pass_cnt++;
    endtask

    task automatic test_rr_conflict();
        // pointer 0: sources 0 and 3 contend for register 5
        bus.src_valid = 6'b001001;
        bus.src_dest[0] = 4'd5;
        bus.src_dest[3] = 4'd5;
        @(negedge clk);
        total_cnt++;
        if (bus.src_ready !== 6'b000001) $display("FAIL rr_first_ready got=%b want=000001", bus.src_ready); else pass_cnt++;
        sb_q.push_back(sel_with(all_hold(), 5, 3'd0));
        tick();
        exp_sel = sb_q.pop_front();
        total_cnt++;
        if (bus.sel_flat !== exp_sel) $display("FAIL rr_first_sel got=%h want=%h", bus.sel_flat, exp_sel); else pass_cnt++;
        bus.src_valid = 6'b001000;
        @(negedge clk);
        total_cnt++;
        if (bus.src_ready !== 6'b001000) $display("FAIL rr_second_ready got=%b want=001000", bus.src_ready); else pass_cnt++;
        sb_q.push_back(sel_with(all_hold(), 5, 3'd3));
        tick();
        exp_sel = sb_q.pop_front();
        total_cnt++;
        if (bus.sel_flat !== exp_sel) $display("FAIL rr_second_sel got=%h want=%h", bus.sel_flat, exp_sel); else pass_cnt++;
        // pointer now 4: source 4 beats source 3 on register 2
        bus.src_valid = 6'b011000;
        bus.src_dest[3] = 4'd2;
        bus.src_dest[4] = 4'd2;
        @(negedge clk);
        total_cnt++;
        if (bus.src_ready !== 6'b010000) $display("FAIL rr_ptr4_ready got=%b want=010000", bus.src_ready); else pass_cnt++;
        sb_q.push_back(sel_with(all_hold(), 2, 3'd4));
        tick();
        exp_sel = sb_q.pop_front();
        total_cnt++;
        if (bus.sel_flat !== exp_sel) $display("FAIL rr_ptr4_sel got=%h want=%h", bus.sel_flat, exp_sel); else pass_cnt++;
        bus.src_valid = 6'b001000;
        @(negedge clk);
        total_cnt++;
        if (bus.src_ready !== 6'b001000) $display("FAIL rr_ptr5_ready got=%b want=001000", bus.src_ready); else pass_cnt++;
        sb_q.push_back(sel_with(all_hold(), 2, 3'd3));
        tick();
        exp_sel = sb_q.pop_front();
        total_cnt++;
        if (bus.sel_flat !== exp_sel) $display("FAIL rr_ptr5_sel got=%h want=%h", bus.sel_flat, exp_sel); else pass_cnt++;
        bus.src_valid = '0;
        sb_q.push_back(all_hold());
        tick();
        exp_sel = sb_q.pop_front();
        total_cnt++;
        if (bus.sel_flat !== exp_sel) $display("FAIL rr_idle_sel got=%h want=%h", bus.sel_flat, exp_sel); else pass_cnt++;
    endtask

    task automatic test_all_distinct();
        logic [47:0] e;
        bus.src_valid = 6'b111111;
        e = all_hold();
        for (int i = 0; i < 6; i++) begin
            bus.src_dest[i] = 4'(i);
            e = sel_with(e, i, 3'(i));
        end
        @(negedge clk);
        total_cnt++;
        if (bus.src_ready !== 6'b111111) $display("FAIL distinct_ready got=%b want=111111", bus.src_ready); else pass_cnt++;
        sb_q.push_back(e);
        tick();
        exp_sel = sb_q.pop_front();
        total_cnt++;
        if (bus.sel_flat !== exp_sel) $display("FAIL distinct_sel got=%h want=%h", bus.sel_flat, exp_sel); else pass_cnt++;
        bus.src_valid = '0;
    endtask

    task automatic test_load();
`ifdef REGSCHED_SCOREBOARD_EN
        exp_busy = 16'h0200;
`else
        exp_busy = 16'h0000;
`endif
        // cycle 0: request load to register 9
        bus.ld_valid = 1'b1;
        bus.ld_dest  = 4'd9;
        bus.ld_addr  = 8'hA5;
        @(negedge clk);
        total_cnt++;
        if (bus.ld_ready !== 1'b1) $display("FAIL load_accept_ready got=%b want=1", bus.ld_ready); else pass_cnt++;
        tick();
        // cycle 1: ISSUE
        bus.ld_valid = 1'b0;
`ifdef REGSCHED_SCOREBOARD_EN
        bus.src_valid   = 6'b000001;
        bus.src_dest[0] = 4'd9;
`endif
        @(negedge clk);
        total_cnt++;
        if (bus.sram_rd !== 1'b1 || bus.sram_addr !== 8'hA5) $display("FAIL load_issue got rd=%b addr=%h want rd=1 addr=a5", bus.sram_rd, bus.sram_addr); else pass_cnt++;
        total_cnt++;
        if (bus.ld_ready !== 1'b0 || bus.busy_mask !== exp_busy) $display("FAIL load_issue_busy got rdy=%b busy=%h want rdy=0 busy=%h", bus.ld_ready, bus.busy_mask, exp_busy); else pass_cnt++;
`ifdef REGSCHED_SCOREBOARD_EN
        total_cnt++;
        if (bus.src_ready !== 6'b000000) $display("FAIL load_issue_block got=%b want=000000", bus.src_ready); else pass_cnt++;
`endif
        tick();
        // cycle 2: reservation
        bus.src_valid   = 6'b000011;
        bus.src_dest[0] = 4'd9;
        bus.src_dest[1] = 4'd10;
        @(negedge clk);
        total_cnt++;
        if (bus.src_ready !== 6'b000010) $display("FAIL load_resv_ready got=%b want=000010", bus.src_ready); else pass_cnt++;
        total_cnt++;
        if (bus.sram_rd !== 1'b0 || bus.ld_done !== 1'b0 || bus.busy_mask !== exp_busy) $display("FAIL load_wait_strobes got rd=%b done=%b busy=%h want 0/0/%h", bus.sram_rd, bus.ld_done, bus.busy_mask, exp_busy); else pass_cnt++;
        sb_q.push_back(sel_with(sel_with(all_hold(), 9, 3'd7), 10, 3'd1));
        tick();
        // cycle 3: WRITE
        exp_sel = sb_q.pop_front();
        total_cnt++;
        if (bus.sel_flat !== exp_sel) $display("FAIL load_write_sel got=%h want=%h", bus.sel_flat, exp_sel); else pass_cnt++;
        total_cnt++;
        if (bus.ld_done !== 1'b1 || bus.ld_ready !== 1'b0) $display("FAIL load_done got done=%b rdy=%b want 1/0", bus.ld_done, bus.ld_ready); else pass_cnt++;
        bus.src_valid = 6'b000001;
        @(negedge clk);
`ifdef REGSCHED_SCOREBOARD_EN
        total_cnt++;
        if (bus.src_ready !== 6'b000000 || bus.busy_mask !== 16'h0200) $display("FAIL load_write_block got=%b busy=%h want=000000 busy=0200", bus.src_ready, bus.busy_mask); else pass_cnt++;
        tick();
        // cycle 4: idle again, held request now accepted
        total_cnt++;
        if (bus.ld_done !== 1'b0 || bus.ld_ready !== 1'b1) $display("FAIL load_return got done=%b rdy=%b want 0/1", bus.ld_done, bus.ld_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.src_ready !== 6'b000001) $display("FAIL load_after_ready got=%b want=000001", bus.src_ready); else pass_cnt++;
        sb_q.push_back(sel_with(all_hold(), 9, 3'd0));
        tick();
`else
        total_cnt++;
        if (bus.src_ready !== 6'b000001) $display("FAIL load_write_ready got=%b want=000001", bus.src_ready); else pass_cnt++;
        sb_q.push_back(sel_with(all_hold(), 9, 3'd0));
        tick();
        // cycle 4: idle again
        total_cnt++;
        if (bus.ld_done !== 1'b0 || bus.ld_ready !== 1'b1) $display("FAIL load_return got done=%b rdy=%b want 0/1", bus.ld_done, bus.ld_ready); else pass_cnt++;
`endif
        exp_sel = sb_q.pop_front();
        total_cnt++;
        if (bus.sel_flat !== exp_sel) $display("FAIL load_after_sel got=%h want=%h", bus.sel_flat, exp_sel); else pass_cnt++;
        bus.src_valid = '0;
    endtask

    task automatic test_reset_mid_load();
`ifdef REGSCHED_SCOREBOARD_EN
        exp_busy = 16'h0008;
`else
        exp_busy = 16'h0000;
`endif
        bus.ld_valid = 1'b1;
        bus.ld_dest  = 4'd3;
        bus.ld_addr  = 8'h3C;
        tick();
        // ISSUE; a source writes register 7 so sel is not idle
        bus.ld_valid    = 1'b0;
        bus.src_valid   = 6'b000100;
        bus.src_dest[2] = 4'd7;
        @(negedge clk);
        total_cnt++;
        if (bus.src_ready !== 6'b000100) $display("FAIL abort_src_ready got=%b want=000100", bus.src_ready); else pass_cnt++;
        sb_q.push_back(sel_with(all_hold(), 7, 3'd2));
        tick();
        // WAIT
        bus.src_valid = '0;
        exp_sel = sb_q.pop_front();
        total_cnt++;
        if (bus.sel_flat !== exp_sel || bus.busy_mask !== exp_busy) $display("FAIL abort_pre_sel got=%h busy=%h want=%h busy=%h", bus.sel_flat, bus.busy_mask, exp_sel, exp_busy); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.sel_flat !== all_hold()) $display("FAIL abort_async_sel got=%h want=%h", bus.sel_flat, all_hold()); else pass_cnt++;
        total_cnt++;
        if (bus.ld_done !== 1'b0 || bus.ld_ready !== 1'b0 || bus.busy_mask !== 16'h0) $display("FAIL abort_async_ctl got done=%b rdy=%b busy=%h want 0/0/0000", bus.ld_done, bus.ld_ready, bus.busy_mask); else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.ld_done !== 1'b0 || bus.sel_flat !== all_hold()) $display("FAIL abort_no_done got done=%b sel=%h want 0/%h", bus.ld_done, bus.sel_flat, all_hold()); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        total_cnt++;
        if (bus.ld_ready !== 1'b1 || bus.ld_done !== 1'b0 || bus.sram_rd !== 1'b0) $display("FAIL abort_release got rdy=%b done=%b rd=%b want 1/0/0", bus.ld_ready, bus.ld_done, bus.sram_rd); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        test_reset();
        tick();
        test_rr_conflict();
        test_all_distinct();
        tick();
        test_load();
        tick();
        test_reset_mid_load();
        total_cnt++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
